// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between NUM_MASTERS requesters.
// Each transaction runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> ACK (1 cycle).
// Arbitration is round-robin by default; define MEM_ARB_FIXED_PRIO_EN for
// fixed priority where the lowest-indexed requester always wins.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0,
  localparam int SEL_W      = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_ce,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [SEL_W-1:0]              s_sel,
  input  logic [DATA_W-1:0]             s_rdata
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [IDX_W-1:0]        r_winner;
  logic [NUM_MASTERS-1:0]  r_ack;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_s_ce;
  logic                    r_s_we;
  logic [ADDR_W-1:0]       r_s_addr;
  logic [DATA_W-1:0]       r_s_wdata;
  logic [SEL_W-1:0]        r_s_sel;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]        r_last_grant;
`endif

  logic                    w_any;
  logic [IDX_W-1:0]        w_grant;
  logic [ADDR_W-1:0]       w_addr  [NUM_MASTERS];
  logic [DATA_W-1:0]       w_wdata [NUM_MASTERS];
  logic [SEL_W-1:0]        w_sel   [NUM_MASTERS];

  // Unpack the per-master buses so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_addr[i]  = m_addr[i*ADDR_W +: ADDR_W];
      w_wdata[i] = m_wdata[i*DATA_W +: DATA_W];
      w_sel[i]   = m_sel[i*SEL_W +: SEL_W];
    end
  end

  // Pick the winner among the current requests.
  always_comb begin
    // NOTE: defaults first so every path assigns w_grant and no latch is inferred.
    w_any   = |m_req;
    w_grant = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest set index is the last to write.
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (m_req[IDX_W'(i)]) w_grant = IDX_W'(i);
    end
`else
    // Scan farthest-first so the nearest requester after last_grant wins.
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (m_req[IDX_W'((int'(r_last_grant) + k) % NUM_MASTERS)])
        w_grant = IDX_W'((int'(r_last_grant) + k) % NUM_MASTERS);
    end
`endif
  end

  // Transaction FSM; all memory-side and master-side outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_winner     <= '0;
      r_ack        <= '0;
      r_rdata      <= '0;
      r_s_ce       <= 1'b0;
      r_s_we       <= 1'b0;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_s_sel      <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_last_grant <= IDX_W'(NUM_MASTERS - 1);
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state      <= ACCESS;
            r_winner     <= w_grant;
            r_cnt        <= CNT_INIT;
            r_s_ce       <= 1'b1;
            r_s_we       <= m_we[w_grant];
            r_s_addr     <= w_addr[w_grant];
            r_s_wdata    <= w_wdata[w_grant];
            r_s_sel      <= w_sel[w_grant];
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last_grant <= w_grant;
`endif
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state   <= ACK;
            r_rdata   <= s_rdata;
            r_ack     <= NUM_MASTERS'(1) << r_winner;
            r_s_ce    <= 1'b0;
            r_s_we    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_sel   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ACK: begin
          r_ack   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_ack   = r_ack;
  assign m_rdata = r_rdata;
  assign s_ce    = r_s_ce;
  assign s_we    = r_s_we;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign s_sel   = r_s_sel;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (2 masters / 0 wait, 4 masters / 3 wait)
// share one behavioural memory; a reference model predicts winners, latency
// and read data from the arbitration rules.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Stimulus shared by both instances; dsel picks which one receives req_mask.
  bit          dsel = 1'b0;
  logic [3:0]  req_mask = '0;
  logic        st_we    [4];
  logic [31:0] st_addr  [4];
  logic [31:0] st_wdata [4];
  logic [3:0]  st_sel   [4];

  // Instance A: 2 masters, no wait states.
  logic [1:0]  a_req, a_we, a_ack;
  logic [63:0] a_addr, a_wdata;
  logic [7:0]  a_sel;
  logic [31:0] a_rdata, a_s_addr, a_s_wdata, a_s_rdata;
  logic        a_s_ce, a_s_we;
  logic [3:0]  a_s_sel;

  // Instance B: 4 masters, 3 wait states.
  logic [3:0]   b_req, b_we, b_ack;
  logic [127:0] b_addr, b_wdata;
  logic [15:0]  b_sel;
  logic [31:0]  b_rdata, b_s_addr, b_s_wdata, b_s_rdata;
  logic         b_s_ce, b_s_we;
  logic [3:0]   b_s_sel;

  mem_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_a (
    .clk(clk), .rst(rst), .m_req(a_req), .m_we(a_we), .m_addr(a_addr),
    .m_wdata(a_wdata), .m_sel(a_sel), .m_ack(a_ack), .m_rdata(a_rdata),
    .s_ce(a_s_ce), .s_we(a_s_we), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
    .s_sel(a_s_sel), .s_rdata(a_s_rdata)
  );

  mem_arbiter #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .m_req(b_req), .m_we(b_we), .m_addr(b_addr),
    .m_wdata(b_wdata), .m_sel(b_sel), .m_ack(b_ack), .m_rdata(b_rdata),
    .s_ce(b_s_ce), .s_we(b_s_we), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_sel(b_s_sel), .s_rdata(b_s_rdata)
  );

  // Pack stimulus arrays onto the instance buses.
  always_comb begin
    a_req = dsel ? 2'b00 : req_mask[1:0];
    b_req = dsel ? req_mask : 4'b0000;
    for (int i = 0; i < 2; i++) begin
      a_we[i]             = st_we[i];
      a_addr[i*32 +: 32]  = st_addr[i];
      a_wdata[i*32 +: 32] = st_wdata[i];
      a_sel[i*4 +: 4]     = st_sel[i];
    end
    for (int i = 0; i < 4; i++) begin
      b_we[i]             = st_we[i];
      b_addr[i*32 +: 32]  = st_addr[i];
      b_wdata[i*32 +: 32] = st_wdata[i];
      b_sel[i*4 +: 4]     = st_sel[i];
    end
  end

  // Behavioural 16-word memory answering both instances.
  logic [31:0] env_mem [16];
  always_comb a_s_rdata = env_mem[a_s_addr[5:2]];
  always_comb b_s_rdata = env_mem[b_s_addr[5:2]];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) env_mem[i] = 32'hC0DE_0000 | i;
    env_mem[4] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (a_s_ce && a_s_we) env_mem[a_s_addr[5:2]] = merge(env_mem[a_s_addr[5:2]], a_s_wdata, a_s_sel);
      if (b_s_ce && b_s_we) env_mem[b_s_addr[5:2]] = merge(env_mem[b_s_addr[5:2]], b_s_wdata, b_s_sel);
    end
  end

  // Common view of whichever instance is active.
  logic [3:0]  v_ack, v_sel;
  logic [31:0] v_rdata, v_addr, v_wdata;
  logic        v_ce, v_we;
  always_comb begin
    v_ack   = dsel ? b_ack     : {2'b00, a_ack};
    v_rdata = dsel ? b_rdata   : a_rdata;
    v_ce    = dsel ? b_s_ce    : a_s_ce;
    v_we    = dsel ? b_s_we    : a_s_we;
    v_addr  = dsel ? b_s_addr  : a_s_addr;
    v_wdata = dsel ? b_s_wdata : a_s_wdata;
    v_sel   = dsel ? b_s_sel   : a_s_sel;
  end

  // Reference model state.
  logic [31:0] ref_mem [16];
  int          lg [2];
  logic [3:0]  last_ack;

  function automatic int pick(input logic [3:0] mask, input int last, input int n);
    int idx;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < n; i++) begin
      idx = i;
      if (mask[idx[1:0]]) return i;
    end
`else
    for (int k = 1; k <= n; k++) begin
      idx = (last + k) % n;
      if (mask[idx[1:0]]) return idx;
    end
`endif
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on the selected instance; called and returns at a negedge.
  task automatic run_txn(input logic [3:0] mask, input bit change_addr);
    int w, nm, wc, n, ce_cnt;
    bit bus_ok, acked;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_sel;
    nm = dsel ? 4 : 2;
    wc = dsel ? 3 : 0;
    w  = pick(mask, lg[dsel], nm);
    lg[dsel]  = w;
    exp_we    = st_we[w];
    exp_addr  = st_addr[w];
    exp_wdata = st_wdata[w];
    exp_sel   = st_sel[w];
    exp_rd    = ref_mem[exp_addr[5:2]];
    if (exp_we) ref_mem[exp_addr[5:2]] = merge(ref_mem[exp_addr[5:2]], exp_wdata, exp_sel);
    req_mask = mask;
    n = 0; ce_cnt = 0; bus_ok = 1'b1; acked = 1'b0;
    while (!acked && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (v_ce) begin
        ce_cnt++;
        if (v_addr !== exp_addr || v_we !== exp_we || v_sel !== exp_sel || v_wdata !== exp_wdata)
          bus_ok = 1'b0;
        if (change_addr) st_addr[0] = st_addr[0] ^ 32'h0000_0008;
      end else if (v_we !== 1'b0 || v_addr !== '0 || v_wdata !== '0 || v_sel !== '0) begin
        bus_ok = 1'b0;
      end
      if (v_ack !== 4'b0000) acked = 1'b1;
    end
    last_ack = v_ack;
    check("ack_winner", {28'b0, v_ack}, 32'(4'b0001 << w));
    check("latency", n, wc + 2);
    check("ce_cycles", ce_cnt, wc + 1);
    check("slave_bus", {31'b0, bus_ok}, 1);
    if (!exp_we) check("rdata", v_rdata, exp_rd);
    req_mask = '0;
    @(negedge clk);
    check("ack_pulse", {27'b0, v_ack, v_ce}, 0);
  endtask

  initial begin
    logic [7:0] seq;
    bit         seen_ack;
    int         nm;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 | i;
    ref_mem[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      st_we[i] = 1'b0; st_addr[i] = '0; st_wdata[i] = '0; st_sel[i] = '0;
    end
    lg[0] = 1; lg[1] = 3;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst_a_out", {a_ack, a_s_ce, a_s_we, a_s_sel} | a_s_addr | a_s_wdata | a_rdata, 0);
    check("rst_b_out", {b_ack, b_s_ce, b_s_we, b_s_sel} | b_s_addr | b_s_wdata | b_rdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Two masters requesting continuously: alternate (round-robin) or all 0 (fixed).
    dsel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st_we[i] = 1'b0; st_addr[i] = 32'h30 + 32'(i*4); st_sel[i] = 4'hF;
    end
    seq = '0;
    for (int t = 0; t < 4; t++) begin
      run_txn(4'b0011, 1'b0);
      seq = {seq[5:0], last_ack[1:0]};
    end
`ifdef MEM_ARB_FIXED_PRIO_EN
    check("grant_seq", {24'b0, seq}, 32'h55);
`else
    check("grant_seq", {24'b0, seq}, 32'h66);
`endif

    // Master 0 reads 0x10 with no wait states.
    st_we[0] = 1'b0; st_addr[0] = 32'h10; st_sel[0] = 4'hF;
    run_txn(4'b0001, 1'b0);
    check("rd_deadbeef", a_rdata, 32'hDEAD_BEEF);

    // Reset while master 0 is in ACCESS: outputs clear at once, no ack.
    st_addr[0] = 32'h14;
    req_mask = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_ce", {31'b0, a_s_ce}, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_out", {a_ack, a_s_ce, a_s_we, a_s_sel} | a_s_addr | a_s_wdata | a_rdata, 0);
    seen_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_ack !== 2'b00) seen_ack = 1'b1;
    end
    check("rst_no_ack", {31'b0, seen_ack}, 0);
    rst = 1'b1;
    lg[0] = 1; lg[1] = 3;
    run_txn(4'b0001, 1'b0);

    // Master 1 write with three wait states, then read it back via master 2.
    dsel = 1'b1;
    st_we[1] = 1'b1; st_addr[1] = 32'h20; st_wdata[1] = 32'h1234_5678; st_sel[1] = 4'b0011;
    run_txn(4'b0010, 1'b0);
    st_we[2] = 1'b0; st_addr[2] = 32'h20; st_sel[2] = 4'hF;
    run_txn(4'b0100, 1'b0);
    check("wr_readback", b_rdata, 32'hC0DE_5678);

    // After a grant to 3, only masters 1 and 3 request.
    st_we[3] = 1'b0; st_addr[3] = 32'h0C; st_sel[3] = 4'hF;
    run_txn(4'b1000, 1'b0);
    run_txn(4'b1010, 1'b0);
    run_txn(4'b1010, 1'b0);
    seq = {4'b0, last_ack};
`ifdef MEM_ARB_FIXED_PRIO_EN
    check("rr4_last", {24'b0, seq}, 32'h02);
`else
    check("rr4_last", {24'b0, seq}, 32'h08);
`endif

    // Master 0 address changes during ACCESS; slave address must stay latched.
    st_we[0] = 1'b0; st_addr[0] = 32'h04; st_sel[0] = 4'hF;
    run_txn(4'b0001, 1'b1);

    // Randomized mix on both instances.
    for (int it = 0; it < 40; it++) begin
      dsel = 1'($urandom_range(0, 1));
      nm   = dsel ? 4 : 2;
      for (int i = 0; i < 4; i++) begin
        st_we[i]    = 1'($urandom_range(0, 1));
        st_addr[i]  = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
        st_wdata[i] = $urandom;
        st_sel[i]   = 4'($urandom);
      end
      run_txn(4'($urandom_range(1, (1 << nm) - 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of requesting masters (legal 2..4).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; byte-select width SEL_W = DATA_W/8.
REQ-004 Parameter WAIT_CYCLES, default 0, extra access cycles per transaction (legal 0..15).
REQ-005 clk  input  1  single system clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 m_req  input  NUM_MASTERS  per-master request, held high until its m_ack.
REQ-008 m_we  input  NUM_MASTERS  per-master write enable (1 = write).
REQ-009 m_addr  input  NUM_MASTERS*ADDR_W  packed addresses, master i at slice i.
REQ-010 m_wdata  input  NUM_MASTERS*DATA_W  packed write data.
REQ-011 m_sel  input  NUM_MASTERS*SEL_W  packed byte selects.
REQ-012 m_ack  output  NUM_MASTERS  one-cycle completion pulse, at most one bit set.
REQ-013 m_rdata  output  DATA_W  shared read data, valid during the m_ack cycle.
REQ-014 s_ce, s_we  output  1 each  shared-memory chip enable and write enable.
REQ-015 s_addr  output  ADDR_W;  s_wdata  output  DATA_W;  s_sel  output  SEL_W.
REQ-016 s_rdata  input  DATA_W  memory read data, valid by the last ACCESS cycle.

Function
REQ-017 FSM states IDLE, ACCESS, ACK; exactly one master owns the memory per transaction.
REQ-018 IDLE: on an edge with any m_req set, select winner, latch its we/addr/wdata/sel, load wait counter with WAIT_CYCLES, go to ACCESS; with no request, stay in IDLE.
REQ-019 ACCESS: s_ce=1 and s_we/s_addr/s_wdata/s_sel driven from latched values; decrement counter each cycle; on the edge with counter==0, capture s_rdata into the read register and go to ACK.
REQ-020 ACCESS lasts exactly WAIT_CYCLES+1 cycles; master inputs changing during ACCESS have no effect.
REQ-021 ACK: s_ce=0, m_ack[winner]=1 for exactly one cycle, then unconditionally go to IDLE; requests are not arbitrated in the ACK cycle.
REQ-022 Latency from req sampled in IDLE to m_ack = WAIT_CYCLES+2 cycles; back-to-back throughput one transaction per WAIT_CYCLES+3 cycles.
REQ-023 Master drops m_req in the cycle after seeing m_ack; a request still high in IDLE is a new transaction.
REQ-024 Round-robin: search starts at last_grant+1 modulo NUM_MASTERS; first set m_req bit wins; last_grant updates on the IDLE->ACCESS edge.
REQ-025 m_rdata holds the last captured value until the next capture; on writes it captures s_rdata too and its value is don't-care.
REQ-026 s_we, s_addr, s_wdata, s_sel are 0 whenever s_ce=0.

Reset
REQ-027 rst low asynchronously forces IDLE, counter 0, read register 0, last_grant = NUM_MASTERS-1 (master 0 wins first), all outputs 0.
REQ-028 Reset mid-ACCESS or mid-ACK aborts the transaction with no m_ack; masters re-request after reset release.

Configuration
REQ-029 Macro MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, last_grant unused; not defined: round-robin per REQ-024.

Verification
REQ-030 WAIT_CYCLES=0, master 0 reads addr 0x10 (memory 0xDEADBEEF) -> s_ce high 1 cycle, m_ack[0] 2 cycles after req, m_rdata=0xDEADBEEF.
REQ-031 WAIT_CYCLES=3, master 1 writes 0x12345678 sel 4'b0011 to 0x20 -> s_ce high 4 cycles with s_we=1, s_sel=0011, m_ack[1] at cycle 5.
REQ-032 Both masters request continuously, round-robin -> grants alternate 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN -> master 0 every transaction.
REQ-033 NUM_MASTERS=4, only masters 1 and 3 request after grant to 3 -> next grant 1, then 3.
REQ-034 rst low during ACCESS of master 0 -> outputs 0 immediately, no m_ack; after release master 0 re-request completes normally.
REQ-035 m_addr[0] changed during ACCESS -> s_addr stays at latched value until ACK.
